// File: rtl/test_pattern_spi_gen.sv
// test_pattern_spi_gen
//
// Test-pattern write sequencer for the SPI memory path. A START strobe in IDLE
// launches a burst of WORD_COUNT writes to consecutive addresses from BASE_ADDR.
// Each word is offered on WRITE_REQ/DATA/WRITE_ADDRESS and advanced when the SPI
// write controller returns WRITE_ACK. Back-to-back acks give one word per cycle.
//
// Pattern modes (latched at START):
//   0: CONST_DATA every word
//   1: incrementing from CONST_DATA
//   2: Galois LFSR seeded with CONST_DATA (zero seed replaced by 1)
//   3: low DATA_WIDTH bits of the current address
//
// Ports:
//   CLK           in   system clock, rising edge
//   RESET_N       in   asynchronous active-low reset
//   START         in   begin a burst (sampled in IDLE only)
//   ABORT         in   terminate the burst, wins over WRITE_ACK
//   MODE          in   pattern select
//   WRITE_ACK     in   current word accepted
//   WRITE_REQ     out  DATA/WRITE_ADDRESS valid, awaiting ack
//   DATA          out  write data
//   WRITE_ADDRESS out  write address
//   BUSY          out  burst in progress
//   DONE          out  one-cycle pulse on normal completion
//   ERROR         out  sticky ack-timeout flag
//
// Optional feature: define TEST_PATTERN_ACK_TIMEOUT_EN to enable the per-word
// ack timeout (ACK_TIMEOUT cycles). Without it ERROR is tied to 0 and the
// sequencer waits for an ack indefinitely.
module test_pattern_spi_gen #(
    parameter int unsigned           DATA_WIDTH  = 16,
    parameter int unsigned           ADDR_WIDTH  = 18,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 18'd29,
    parameter int unsigned           WORD_COUNT  = 16,
    parameter logic [DATA_WIDTH-1:0] CONST_DATA  = 16'hA5C3,
    parameter logic [DATA_WIDTH-1:0] LFSR_TAPS   = 16'hB400,
    parameter int unsigned           ACK_TIMEOUT = 255
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  START,
    input  logic                  ABORT,
    input  logic [1:0]            MODE,
    input  logic                  WRITE_ACK,
    output logic                  WRITE_REQ,
    output logic [DATA_WIDTH-1:0] DATA,
    output logic [ADDR_WIDTH-1:0] WRITE_ADDRESS,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  ERROR
);

    localparam int unsigned CNT_W = $clog2(WORD_COUNT + 1);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORD_COUNT - 1);
    // An all-zero seed would lock the LFSR at zero.
    localparam logic [DATA_WIDTH-1:0] LFSR_SEED =
        (CONST_DATA == '0) ? DATA_WIDTH'(1) : CONST_DATA;

    typedef enum logic [1:0] {StIdle, StWrite, StFinish} state_e;

    state_e                state_q, state_d;
    logic [1:0]            mode_q, mode_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  req_q, req_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [ADDR_WIDTH-1:0] addr_next;

`ifdef TEST_PATTERN_ACK_TIMEOUT_EN
    localparam int unsigned WAIT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

    logic              error_q, error_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
`endif

    // Zero-extends or truncates the address to the data width.
    function automatic logic [DATA_WIDTH-1:0] addr_to_data(input logic [ADDR_WIDTH-1:0] a);
        return DATA_WIDTH'(a);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] lfsr_step(input logic [DATA_WIDTH-1:0] d);
        return d[0] ? ((d >> 1) ^ LFSR_TAPS) : (d >> 1);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] first_word(input logic [1:0] mode);
        case (mode)
            2'd0, 2'd1: return CONST_DATA;
            2'd2:       return LFSR_SEED;
            default:    return addr_to_data(BASE_ADDR);
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] next_word(input logic [1:0]            mode,
                                                        input logic [DATA_WIDTH-1:0] d,
                                                        input logic [ADDR_WIDTH-1:0] a);
        case (mode)
            2'd0:    return CONST_DATA;
            2'd1:    return d + DATA_WIDTH'(1);
            2'd2:    return lfsr_step(d);
            default: return addr_to_data(a);
        endcase
    endfunction

    assign addr_next = addr_q + ADDR_WIDTH'(1);

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        count_d = count_q;
        addr_d  = addr_q;
        data_d  = data_q;
        req_d   = req_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef TEST_PATTERN_ACK_TIMEOUT_EN
        error_d = error_q;
        wait_d  = wait_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (START && !ABORT) begin
                    mode_d  = MODE;
                    count_d = '0;
                    addr_d  = BASE_ADDR;
                    data_d  = first_word(MODE);
                    req_d   = 1'b1;
                    busy_d  = 1'b1;
                    state_d = StWrite;
`ifdef TEST_PATTERN_ACK_TIMEOUT_EN
                    error_d = 1'b0;
                    wait_d  = '0;
`endif
                end
            end
            StWrite: begin
                if (ABORT) begin
                    req_d   = 1'b0;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else if (WRITE_ACK) begin
`ifdef TEST_PATTERN_ACK_TIMEOUT_EN
                    wait_d = '0;
`endif
                    if (count_q == LAST_WORD) begin
                        req_d   = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = StFinish;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                        addr_d  = addr_next;
                        data_d  = next_word(mode_q, data_q, addr_next);
                    end
                end
`ifdef TEST_PATTERN_ACK_TIMEOUT_EN
                else if (wait_q == WAIT_LAST) begin
                    error_d = 1'b1;
                    req_d   = 1'b0;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
`endif
            end
            StFinish: begin
                // DONE was raised on entry and drops here; ABORT lands in IDLE too.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                req_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= StIdle;
            mode_q  <= 2'd0;
            count_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef TEST_PATTERN_ACK_TIMEOUT_EN
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            error_q <= 1'b0;
            wait_q  <= '0;
        end else begin
            error_q <= error_d;
            wait_q  <= wait_d;
        end
    end

    assign ERROR = error_q;
`else
    logic unused_ack_timeout;
    assign unused_ack_timeout = ^ACK_TIMEOUT;
    assign ERROR = 1'b0;
`endif

    assign WRITE_REQ     = req_q;
    assign DATA          = data_q;
    assign WRITE_ADDRESS = addr_q;
    assign BUSY          = busy_q;
    assign DONE          = done_q;

endmodule

// File: tb/tb_test_pattern_spi_gen.sv
// Directed bench for test_pattern_spi_gen. Three instances share the inputs:
// the default build (ACK_TIMEOUT=8), a zero-seed instance and an address-wrap
// instance, both with four-word bursts.
module tb_test_pattern_spi_gen;

    logic        CLK = 1'b0;
    logic        RESET_N, START, ABORT, WRITE_ACK;
    logic [1:0]  MODE;

    logic        WRITE_REQ, BUSY, DONE, ERROR;
    logic [15:0] DATA;
    logic [17:0] WRITE_ADDRESS;

    logic        l_req, l_busy, l_done, l_error;
    logic [15:0] l_data;
    logic [17:0] l_addr;

    logic        w_req, w_busy, w_done, w_error;
    logic [15:0] w_data;
    logic [17:0] w_addr;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] lfsr_a5[4]  = '{16'hA5C3, 16'hE6E1, 16'hC770, 16'h63B8};
    logic [15:0] lfsr_0[4]   = '{16'h0001, 16'hB400, 16'h5A00, 16'h2D00};
    logic [17:0] wrap_addr[4] = '{18'h3FFFE, 18'h3FFFF, 18'h00000, 18'h00001};
    logic [15:0] wrap_data[4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    int          gaps[16]    = '{0, 1, 2, 3, 0, 2, 1, 3, 0, 0, 3, 1, 2, 0, 1, 2};

    always #5 CLK = ~CLK;

    test_pattern_spi_gen #(.ACK_TIMEOUT(8)) u_dut (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .ABORT(ABORT), .MODE(MODE),
        .WRITE_ACK(WRITE_ACK), .WRITE_REQ(WRITE_REQ), .DATA(DATA),
        .WRITE_ADDRESS(WRITE_ADDRESS), .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR)
    );

    test_pattern_spi_gen #(.CONST_DATA(16'h0000), .WORD_COUNT(4)) u_dut_seed0 (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .ABORT(ABORT), .MODE(MODE),
        .WRITE_ACK(WRITE_ACK), .WRITE_REQ(l_req), .DATA(l_data),
        .WRITE_ADDRESS(l_addr), .BUSY(l_busy), .DONE(l_done), .ERROR(l_error)
    );

    test_pattern_spi_gen #(.BASE_ADDR(18'h3FFFE), .WORD_COUNT(4)) u_dut_wrap (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .ABORT(ABORT), .MODE(MODE),
        .WRITE_ACK(WRITE_ACK), .WRITE_REQ(w_req), .DATA(w_data),
        .WRITE_ADDRESS(w_addr), .BUSY(w_busy), .DONE(w_done), .ERROR(w_error)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic start_burst(input logic [1:0] mode);
        MODE  = mode;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    // Bounded wait for the main instance to return to IDLE.
    task automatic wait_idle();
        int n = 0;
        while ((BUSY || DONE || WRITE_REQ) && n < 100) begin
            @(negedge CLK);
            n++;
        end
        check_eq("idle_reached", 32'(BUSY || DONE || WRITE_REQ), 'h0);
    endtask

    initial begin
        RESET_N   = 1'b0;
        START     = 1'b0;
        ABORT     = 1'b0;
        WRITE_ACK = 1'b0;
        MODE      = 2'd0;
        repeat (2) @(negedge CLK);

        check_eq("rst_req",  32'(WRITE_REQ), 'h0);
        check_eq("rst_busy", 32'(BUSY), 'h0);
        check_eq("rst_done", 32'(DONE), 'h0);
        check_eq("rst_err",  32'(ERROR), 'h0);
        check_eq("rst_data", 32'(DATA), 'h0);
        check_eq("rst_addr", 32'(WRITE_ADDRESS), 'h0);
        RESET_N = 1'b1;
        @(negedge CLK);

        // Constant pattern, ack held high; a stray START mid-burst is ignored.
        WRITE_ACK = 1'b1;
        start_burst(2'd0);
        for (int i = 0; i < 16; i++) begin
            check_eq("m0_addr", 32'(WRITE_ADDRESS), 32'(29 + i));
            check_eq("m0_data", 32'(DATA), 'hA5C3);
            check_eq("m0_req",  32'(WRITE_REQ), 'h1);
            check_eq("m0_busy", 32'(BUSY), 'h1);
            check_eq("m0_done_early", 32'(DONE), 'h0);
            START = (i == 5);
            @(negedge CLK);
        end
        START = 1'b0;
        check_eq("m0_done",      32'(DONE), 'h1);
        check_eq("m0_busy_fin",  32'(BUSY), 'h0);
        check_eq("m0_req_fin",   32'(WRITE_REQ), 'h0);
        check_eq("m0_addr_hold", 32'(WRITE_ADDRESS), 'd44);
        @(negedge CLK);
        check_eq("m0_done_once", 32'(DONE), 'h0);
        check_eq("m0_idle_req",  32'(WRITE_REQ), 'h0);

        // Incrementing pattern with ack gaps; each word must hold while unacked.
        WRITE_ACK = 1'b0;
        start_burst(2'd1);
        for (int i = 0; i < 16; i++) begin
            for (int g = 0; g < gaps[i]; g++) begin
                check_eq("m1_hold_data", 32'(DATA), 32'(16'hA5C3 + 16'(i)));
                check_eq("m1_hold_req",  32'(WRITE_REQ), 'h1);
                @(negedge CLK);
            end
            check_eq("m1_data", 32'(DATA), 32'(16'hA5C3 + 16'(i)));
            check_eq("m1_addr", 32'(WRITE_ADDRESS), 32'(29 + i));
            WRITE_ACK = 1'b1;
            @(negedge CLK);
            WRITE_ACK = 1'b0;
        end
        check_eq("m1_done", 32'(DONE), 'h1);
        check_eq("m1_last_data", 32'(DATA), 'hA5D2);
        @(negedge CLK);

        // LFSR, main seed A5C3 and the zero-seed instance side by side.
        WRITE_ACK = 1'b1;
        start_burst(2'd2);
        for (int i = 0; i < 4; i++) begin
            check_eq("m2_data",       32'(DATA), 32'(lfsr_a5[i]));
            check_eq("m2_seed0_data", 32'(l_data), 32'(lfsr_0[i]));
            @(negedge CLK);
        end
        check_eq("m2_seed0_done", 32'(l_done), 'h1);
        wait_idle();

        // Address-as-data, with the wrap instance crossing all-ones to zero.
        start_burst(2'd3);
        for (int i = 0; i < 4; i++) begin
            check_eq("m3_wrap_addr", 32'(w_addr), 32'(wrap_addr[i]));
            check_eq("m3_wrap_data", 32'(w_data), 32'(wrap_data[i]));
            check_eq("m3_data",      32'(DATA), 32'(29 + i));
            @(negedge CLK);
        end
        check_eq("m3_wrap_done", 32'(w_done), 'h1);
        wait_idle();

        // ABORT together with the 5th ack.
        start_burst(2'd0);
        repeat (4) @(negedge CLK);
        check_eq("ab_addr_pre", 32'(WRITE_ADDRESS), 'd33);
        ABORT = 1'b1;
        @(negedge CLK);
        ABORT = 1'b0;
        check_eq("ab_req",  32'(WRITE_REQ), 'h0);
        check_eq("ab_busy", 32'(BUSY), 'h0);
        check_eq("ab_done", 32'(DONE), 'h0);
        check_eq("ab_addr_hold", 32'(WRITE_ADDRESS), 'd33);
        @(negedge CLK);
        check_eq("ab_no_done", 32'(DONE), 'h0);
        start_burst(2'd0);
        check_eq("ab_restart_addr", 32'(WRITE_ADDRESS), 'd29);
        check_eq("ab_restart_req",  32'(WRITE_REQ), 'h1);
        wait_idle();

        // Asynchronous reset mid-burst.
        start_burst(2'd1);
        repeat (3) @(negedge CLK);
        #2 RESET_N = 1'b0;
        #1;
        check_eq("arst_req",  32'(WRITE_REQ), 'h0);
        check_eq("arst_busy", 32'(BUSY), 'h0);
        check_eq("arst_data", 32'(DATA), 'h0);
        check_eq("arst_addr", 32'(WRITE_ADDRESS), 'h0);
        @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);
        check_eq("arst_no_done", 32'(DONE), 'h0);

        // Ack never arrives.
        WRITE_ACK = 1'b0;
        start_burst(2'd0);
`ifdef TEST_PATTERN_ACK_TIMEOUT_EN
        repeat (7) @(negedge CLK);
        check_eq("to_req_wait", 32'(WRITE_REQ), 'h1);
        check_eq("to_err_wait", 32'(ERROR), 'h0);
        @(negedge CLK);
        check_eq("to_err",  32'(ERROR), 'h1);
        check_eq("to_req",  32'(WRITE_REQ), 'h0);
        check_eq("to_busy", 32'(BUSY), 'h0);
        @(negedge CLK);
        check_eq("to_done", 32'(DONE), 'h0);
        check_eq("to_err_sticky", 32'(ERROR), 'h1);
        start_burst(2'd0);
        check_eq("to_err_clear", 32'(ERROR), 'h0);
        check_eq("to_restart_req", 32'(WRITE_REQ), 'h1);
`else
        repeat (300) @(negedge CLK);
        check_eq("stall_req",  32'(WRITE_REQ), 'h1);
        check_eq("stall_busy", 32'(BUSY), 'h1);
        check_eq("stall_err",  32'(ERROR), 'h0);
        check_eq("stall_addr", 32'(WRITE_ADDRESS), 'd29);
`endif
        ABORT = 1'b1;
        @(negedge CLK);
        ABORT = 1'b0;
        check_eq("stall_abort_req", 32'(WRITE_REQ), 'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
